// File: rtl/keypad_if.sv
// keypad_if: keypad pins and debounced key-event outputs of the scanner.
interface keypad_if #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int CODE_W = $clog2(ROWS*COLS)
);
  logic [COLS-1:0]   col;
  logic [ROWS-1:0]   row;
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_held;
  logic              key_release;
  logic              multi_key;
  modport master (input col, output row, key_valid, key_code, key_held, key_release, multi_key);
  modport slave (output col, input row, key_valid, key_code, key_held, key_release, multi_key);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix scanner with frame debounce, ghost rejection and auto-repeat.
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int SCAN_DIV = 1000000,
  parameter int DEBOUNCE = 3,
  parameter int REPEAT_FRAMES = 0,
  parameter int CODE_W = $clog2(ROWS*COLS)
) (
  input logic    clk,
  input logic    init,
  keypad_if.master kp
);
  localparam int N = ROWS*COLS;
  localparam int CW = $clog2(N+1);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(ROWS);
  localparam int SW = $clog2(DEBOUNCE+1);
  localparam int PW = REPEAT_FRAMES > 0 ? $clog2(REPEAT_FRAMES+1) : 1;
  localparam logic [CW-1:0] NONE = CW'(N);
  logic [DW-1:0] dwell;
  logic [RW-1:0] row_idx;
  logic [N-1:0]  snap, snap_n;
  logic [CW-1:0] prev, cand, hit, ones, committed;
  logic [SW-1:0] stable_cnt, cnt_n;
  logic [PW-1:0] rep_cnt, rep_n;
  logic last_dwell, frame_end, multi, first, accept, rel, rep_fire;
  assign last_dwell = dwell == DW'(SCAN_DIV-1);
  assign frame_end = last_dwell && row_idx == RW'(ROWS-1);
  assign kp.row = ROWS'(1) << row_idx;
  assign committed = kp.key_held ? CW'(kp.key_code) : NONE;
  // Classification sees the snapshot including the latch happening this cycle.
  always_comb begin
    snap_n = snap;
    if (last_dwell) snap_n[row_idx*COLS +: COLS] = kp.col;
    ones = '0;
    hit = '0;
    for (int i = 0; i < N; i++) if (snap_n[i]) begin
      ones = ones + CW'(1);
      hit = CW'(i);
    end
    multi = ones > CW'(1);
    cand = ones == CW'(1) ? hit : NONE;
    cnt_n = cand != prev ? SW'(1) : stable_cnt == SW'(DEBOUNCE) ? stable_cnt : stable_cnt + SW'(1);
    first = cnt_n == SW'(DEBOUNCE) && !(cand == prev && stable_cnt == SW'(DEBOUNCE));
    accept = first && cand != NONE && cand != committed;
    rel = first && cand == NONE && kp.key_held;
    rep_fire = 1'b0;
    rep_n = rep_cnt;
    if (accept) rep_n = '0;
    else if (REPEAT_FRAMES > 0 && cnt_n == SW'(DEBOUNCE) && kp.key_held && cand == committed) begin
      rep_fire = rep_cnt == PW'(REPEAT_FRAMES-1);
      rep_n = rep_fire ? '0 : rep_cnt + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (init) begin
      dwell <= '0;
      row_idx <= '0;
      snap <= '0;
      prev <= NONE;
      stable_cnt <= '0;
      rep_cnt <= '0;
      kp.key_valid <= 1'b0;
      kp.key_release <= 1'b0;
      kp.key_held <= 1'b0;
      kp.key_code <= '0;
      kp.multi_key <= 1'b0;
    end else begin
      dwell <= last_dwell ? '0 : dwell + DW'(1);
      if (last_dwell) row_idx <= row_idx == RW'(ROWS-1) ? '0 : row_idx + RW'(1);
      snap <= snap_n;
      kp.key_valid <= frame_end && (accept || rep_fire);
      kp.key_release <= frame_end && rel;
      if (frame_end) begin
        prev <= cand;
        stable_cnt <= cnt_n;
        rep_cnt <= rep_n;
        kp.multi_key <= multi;
        if (accept) begin
          kp.key_code <= cand[CODE_W-1:0];
          kp.key_held <= 1'b1;
        end
        if (rel) kp.key_held <= 1'b0;
      end
    end
  end
endmodule
